// File: rtl/m_issue_ctrl_pkg.sv
// Shared types for the issue controller: instruction kinds, issue FSM states, trap causes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package m_issue_ctrl_pkg;

   // Instruction classes. KIND_INVALID is zero so a cleared register reads as "nothing valid".
   typedef enum logic [2:0] {
      KIND_INVALID = 3'd0,
      KIND_RRR     = 3'd1,
      KIND_RRI     = 3'd2,
      KIND_MEMORY  = 3'd3,
      KIND_MODEL   = 3'd4,
      KIND_CUSTOM  = 3'd5
   } e_kind;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HELD  = 2'd1,
      TRAP  = 2'd2
   } e_issue_state;

   localparam logic [3:0] TRAP_CAUSE_ILLEGAL = 4'd2;

   // Both register formats go to the ALU.
   function automatic logic is_alu_kind(input e_kind k);
      return (k == KIND_RRR) || (k == KIND_RRI);
   endfunction

endpackage

// File: rtl/m_decoder_kind.sv
// Purely combinational classifier of a raw instruction word into an e_kind.
// Latency: 0 cycles.
// Backpressure: none; output follows the input word.
//
// Ports:
//   instruction  raw 32-bit word
//   kind         classification from the top opcode bits
//
// Encoding: [31:30]=00 selects a base group refined by [29:28]
// (00 RRR, 01 MEMORY, 10 MODEL, 11 reserved); 01 is RRI, 11 is CUSTOM, 10 is reserved.
module m_decoder_kind
   import m_issue_ctrl_pkg::*;
(
   input  logic [31:0] instruction,
   output e_kind       kind
);

   // Operand fields are not needed for classification.
   logic unused_bits;
   assign unused_bits = ^instruction[27:0];

   always_comb begin
      kind = KIND_INVALID;
      case (instruction[31:30])
         2'b00: begin
            case (instruction[29:28])
               2'b00:   kind = KIND_RRR;
               2'b01:   kind = KIND_MEMORY;
               2'b10:   kind = KIND_MODEL;
               default: kind = KIND_INVALID;
            endcase
         end
         2'b01:   kind = KIND_RRI;
         2'b11:   kind = KIND_CUSTOM;
         default: kind = KIND_INVALID;
      endcase
   end

endmodule

// File: rtl/m_mem_credit.sv
// Saturating up/down counter of memory operations in flight.
// Latency: count updates on the edge after inc/dec; full/zero decode from the register.
// Backpressure: caller must not inc while full; inc at full and dec at zero are dropped.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   inc        one operation issued this cycle
//   dec        one operation retired this cycle
//   full       count == MEM_DEPTH
//   zero       count == 0
module m_mem_credit #(
   parameter int MEM_DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic zero
);

   localparam int CW = $clog2(MEM_DEPTH + 1);

   logic [CW-1:0] count;
   logic          inc_eff;
   logic          dec_eff;

   assign full    = (count == CW'(MEM_DEPTH));
   assign zero    = (count == '0);
   assign inc_eff = inc && !full;
   assign dec_eff = dec && !zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc_eff && !dec_eff) begin
         count <= count + 1'b1;
      end else if (dec_eff && !inc_eff) begin
         count <= count - 1'b1;
      end
   end

   // A retire with nothing outstanding means the memory unit and this counter disagree.
   a_no_underflow : assert property (@(posedge clk) disable iff (rst) !(dec && zero));

endmodule

// File: rtl/m_issue_ctrl.sv
// Single-entry decode/dispatch: classify, hold one instruction, hand it to ALU/mem/model/custom.
// Latency: unit valid 1 cycle after accept; 1 instr/cycle when the target unit is ready.
// Backpressure: in_ready only when empty or the held instruction fires this cycle; mem gated by credit, model fenced on zero.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              fetch handshake; in_instruction, in_pc carried with it
//   out_instruction/out_pc/out_kind  held instruction, shared by all units
//   alu_/mem_/model_/custom_valid/ready  per-unit handshakes
//   mem_done                       pulse per retired memory operation
//   trap_valid/trap_pc/trap_ack    illegal-instruction trap
//   flush                          drop held instruction or pending trap
module m_issue_ctrl
   import m_issue_ctrl_pkg::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int MEM_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_instruction,
   input  logic [PC_WIDTH-1:0] in_pc,
   output logic [31:0]         out_instruction,
   output logic [PC_WIDTH-1:0] out_pc,
   output e_kind               out_kind,
   output logic                alu_valid,
   input  logic                alu_ready,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic                model_valid,
   input  logic                model_ready,
   output logic                custom_valid,
   input  logic                custom_ready,
   input  logic                mem_done,
   output logic                trap_valid,
   output logic [PC_WIDTH-1:0] trap_pc,
   input  logic                trap_ack,
   input  logic                flush
);

   e_issue_state state_q;
   e_issue_state state_d;
   e_kind        dec_kind;
   logic         held;
   logic         fire;
   logic         accept;
   logic         mem_fire;
   logic         mem_full;
   logic         mem_zero;

   m_decoder_kind u_decoder (
      .instruction (in_instruction),
      .kind        (dec_kind)
   );

   // A fire in a flush cycle still reached the memory unit, so it is credited.
   assign mem_fire = mem_valid && mem_ready;

   m_mem_credit #(
      .MEM_DEPTH (MEM_DEPTH)
   ) u_credit (
      .clk  (clk),
      .rst  (rst),
      .inc  (mem_fire),
      .dec  (mem_done),
      .full (mem_full),
      .zero (mem_zero)
   );

   // Unit valids decode from registered state only. While one is up the counter
   // can only move toward releasing its gate, so an asserted valid never drops.
   assign held         = (state_q == HELD);
   assign alu_valid    = held && is_alu_kind(out_kind);
   assign mem_valid    = held && (out_kind == KIND_MEMORY) && !mem_full;
   assign model_valid  = held && (out_kind == KIND_MODEL) && mem_zero;
   assign custom_valid = held && (out_kind == KIND_CUSTOM);
   assign trap_valid   = (state_q == TRAP);

   assign fire = (alu_valid    && alu_ready)   ||
                 (mem_valid    && mem_ready)   ||
                 (model_valid  && model_ready) ||
                 (custom_valid && custom_ready);

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      accept   = 1'b0;

      case (state_q)
         EMPTY: in_ready = 1'b1;
         HELD: begin
            in_ready = fire;
            if (fire) state_d = EMPTY;
         end
         TRAP: begin
            if (trap_ack) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase

      if (rst || flush) in_ready = 1'b0;

      accept = in_valid && in_ready;
      if (accept) begin
         state_d = (dec_kind == KIND_INVALID) ? TRAP : HELD;
      end

      if (flush) state_d = EMPTY;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= EMPTY;
         out_instruction <= '0;
         out_pc          <= '0;
         out_kind        <= KIND_INVALID;
         trap_pc         <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_instruction <= in_instruction;
            out_pc          <= in_pc;
            out_kind        <= dec_kind;
            if (dec_kind == KIND_INVALID) trap_pc <= in_pc;
         end
      end
   end

endmodule

// File: tb/tb_m_issue_ctrl.sv
module tb_m_issue_ctrl;
   import m_issue_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instruction;
   logic [31:0] in_pc;
   logic [31:0] out_instruction;
   logic [31:0] out_pc;
   e_kind       out_kind;
   logic        alu_valid, alu_ready;
   logic        mem_valid, mem_ready;
   logic        model_valid, model_ready;
   logic        custom_valid, custom_ready;
   logic        mem_done;
   logic        trap_valid;
   logic [31:0] trap_pc;
   logic        trap_ack;
   logic        flush;

   int n_checks = 0;
   int n_fail   = 0;

   m_issue_ctrl #(.PC_WIDTH(32), .MEM_DEPTH(2)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_pc(in_pc),
      .out_instruction(out_instruction), .out_pc(out_pc), .out_kind(out_kind),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .model_valid(model_valid), .model_ready(model_ready),
      .custom_valid(custom_valid), .custom_ready(custom_ready),
      .mem_done(mem_done),
      .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_ack(trap_ack),
      .flush(flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task tick();
      @(posedge clk);
      #1;
   endtask

   task test_reset();
      rst = 1'b1; in_valid = 1'b0; in_instruction = '0; in_pc = '0;
      alu_ready = 1'b1; mem_ready = 1'b1; model_ready = 1'b1; custom_ready = 1'b1;
      mem_done = 1'b0; trap_ack = 1'b0; flush = 1'b0;
      tick(); tick();
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++; if ({alu_valid, mem_valid, model_valid, custom_valid, trap_valid} !== 5'b0) begin
         n_fail++; $display("FAIL reset_valids: got %b want 00000", {alu_valid, mem_valid, model_valid, custom_valid, trap_valid}); end
      n_checks++; if (out_kind !== KIND_INVALID) begin n_fail++; $display("FAIL reset_kind: got %0d want %0d", out_kind, KIND_INVALID); end
      n_checks++; if ({out_instruction, out_pc, trap_pc} !== 96'b0) begin
         n_fail++; $display("FAIL reset_regs: got %h %h %h want 0", out_instruction, out_pc, trap_pc); end
      n_checks++; if (dut.u_credit.count !== 0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dut.u_credit.count); end
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
   endtask

   task test_back_to_back();
      in_valid = 1'b1; in_instruction = 32'h0000_0000; in_pc = 32'h10;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", in_ready); end
      tick();
      in_instruction = 32'h4000_0000; in_pc = 32'h14;
      #1;
      n_checks++; if ({alu_valid, in_ready, out_kind} !== {2'b11, KIND_RRR}) begin
         n_fail++; $display("FAIL b2b_rrr: got alu=%b rdy=%b kind=%0d want 1 1 %0d", alu_valid, in_ready, out_kind, KIND_RRR); end
      tick();
      in_instruction = 32'hC000_0000; in_pc = 32'h18;
      #1;
      n_checks++; if ({alu_valid, in_ready, out_kind, out_pc} !== {2'b11, KIND_RRI, 32'h14}) begin
         n_fail++; $display("FAIL b2b_rri: got alu=%b rdy=%b kind=%0d pc=%h want 1 1 %0d 14", alu_valid, in_ready, out_kind, out_pc, KIND_RRI); end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++; if ({custom_valid, alu_valid, in_ready} !== 3'b101) begin
         n_fail++; $display("FAIL b2b_custom: got cus=%b alu=%b rdy=%b want 1 0 1", custom_valid, alu_valid, in_ready); end
      tick();
      n_checks++; if (custom_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", custom_valid); end
   endtask

   task test_mem_credit();
      in_valid = 1'b1; in_instruction = 32'h1000_0000; in_pc = 32'h20;
      tick();
      #1;
      n_checks++; if ({mem_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL mem_fire1: got %b want 11", {mem_valid, in_ready}); end
      tick();
      #1;
      n_checks++; if ({mem_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL mem_fire2: got %b want 11", {mem_valid, in_ready}); end
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++; if ({mem_valid, in_ready} !== 2'b00) begin n_fail++; $display("FAIL mem_stall: got %b want 00", {mem_valid, in_ready}); end
      n_checks++; if (dut.u_credit.count !== 2) begin n_fail++; $display("FAIL mem_count_full: got %0d want 2", dut.u_credit.count); end
      tick();
      n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mem_stall2: got %b want 0", mem_valid); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      #1;
      n_checks++; if ({mem_valid, in_ready} !== 2'b11) begin n_fail++; $display("FAIL mem_release: got %b want 11", {mem_valid, in_ready}); end
      tick();
      mem_done = 1'b1;
      tick(); tick();
      mem_done = 1'b0;
      #1;
      n_checks++; if (dut.u_credit.count !== 0) begin n_fail++; $display("FAIL mem_drain: got %0d want 0", dut.u_credit.count); end
   endtask

   task test_model_fence();
      in_valid = 1'b1; in_instruction = 32'h1000_0000; in_pc = 32'h30;
      tick();
      in_instruction = 32'h2000_0000; in_pc = 32'h34;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (model_valid !== 1'b0) begin n_fail++; $display("FAIL fence_wait%0d: got %b want 0", i, model_valid); end
         tick();
      end
      mem_done = 1'b1;
      #1;
      n_checks++; if (model_valid !== 1'b0) begin n_fail++; $display("FAIL fence_done_cycle: got %b want 0", model_valid); end
      tick();
      mem_done = 1'b0;
      #1;
      n_checks++; if (model_valid !== 1'b1) begin n_fail++; $display("FAIL fence_release: got %b want 1", model_valid); end
      tick();
   endtask

   task test_trap();
      logic [31:0] words [2];
      logic [31:0] pcs [2];
      words[0] = 32'h3000_0000; pcs[0] = 32'h100;
      words[1] = 32'h8FFF_FFFF; pcs[1] = 32'h200;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_instruction = words[i]; in_pc = pcs[i];
         tick();
         in_valid = 1'b0;
         #1;
         n_checks++; if ({trap_valid, in_ready, trap_pc} !== {2'b10, pcs[i]}) begin
            n_fail++; $display("FAIL trap%0d: got tv=%b rdy=%b pc=%h want 1 0 %h", i, trap_valid, in_ready, trap_pc, pcs[i]); end
         n_checks++; if ({alu_valid, mem_valid, model_valid, custom_valid} !== 4'b0) begin
            n_fail++; $display("FAIL trap%0d_units: got %b want 0000", i, {alu_valid, mem_valid, model_valid, custom_valid}); end
         if (i == 0) begin
            tick();
            n_checks++; if ({trap_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL trap_hold: got %b want 10", {trap_valid, in_ready}); end
         end
         trap_ack = 1'b1;
         tick();
         trap_ack = 1'b0;
         #1;
         n_checks++; if ({trap_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL trap%0d_ack: got %b want 01", i, {trap_valid, in_ready}); end
      end
   endtask

   task test_flush();
      in_valid = 1'b1; in_instruction = 32'h1000_0000; in_pc = 32'h300;
      tick();
      in_pc = 32'h304;
      tick();
      in_valid = 1'b0; mem_ready = 1'b0;
      #1;
      n_checks++; if ({mem_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL flush_held: got %b want 10", {mem_valid, in_ready}); end
      flush = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", in_ready); end
      tick();
      flush = 1'b0;
      #1;
      n_checks++; if ({mem_valid, dut.state_q} !== {1'b0, EMPTY}) begin
         n_fail++; $display("FAIL flush_empty: got mv=%b st=%0d want 0 %0d", mem_valid, dut.state_q, EMPTY); end
      n_checks++; if (dut.u_credit.count !== 1) begin n_fail++; $display("FAIL flush_count: got %0d want 1", dut.u_credit.count); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0; mem_ready = 1'b1;
   endtask

   task test_reset_mid();
      alu_ready = 1'b0;
      in_valid = 1'b1; in_instruction = 32'h4000_0005; in_pc = 32'h44;
      tick();
      in_valid = 1'b0;
      #1;
      n_checks++; if ({alu_valid, in_ready} !== 2'b10) begin n_fail++; $display("FAIL rstmid_held: got %b want 10", {alu_valid, in_ready}); end
      rst = 1'b1;
      tick();
      rst = 1'b0; alu_ready = 1'b1;
      #1;
      n_checks++; if ({out_instruction, out_pc, trap_pc} !== 96'b0) begin
         n_fail++; $display("FAIL rstmid_regs: got %h %h %h want 0", out_instruction, out_pc, trap_pc); end
      n_checks++; if ({alu_valid, trap_valid, in_ready, out_kind} !== {3'b001, KIND_INVALID}) begin
         n_fail++; $display("FAIL rstmid_ctrl: got alu=%b tv=%b rdy=%b kind=%0d want 0 0 1 0", alu_valid, trap_valid, in_ready, out_kind); end
   endtask

   task test_simultaneous();
      in_valid = 1'b1; in_instruction = 32'h1000_0000; in_pc = 32'h50;
      tick();
      tick();
      in_valid = 1'b0; mem_done = 1'b1;
      #1;
      n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL simul_fire: got %b want 1", mem_valid); end
      n_checks++; if (dut.u_credit.count !== 1) begin n_fail++; $display("FAIL simul_pre: got %0d want 1", dut.u_credit.count); end
      tick();
      mem_done = 1'b0;
      #1;
      n_checks++; if (dut.u_credit.count !== 1) begin n_fail++; $display("FAIL simul_count: got %0d want 1", dut.u_credit.count); end
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      #1;
      n_checks++; if (dut.u_credit.count !== 0) begin n_fail++; $display("FAIL simul_drain: got %0d want 0", dut.u_credit.count); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_mem_credit();
      test_model_fence();
      test_trap();
      test_flush();
      test_reset_mid();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
